si570_freq_sequencer: RTL

- Consumes the one-cycle debounced push-button pulse from the Si570 board button path.
- On each pulse, advances a 2-bit frequency-preset index and programs the Si570 over the downstream I2C byte-writer.
- Programming is a fixed 9-write sequence: freeze DCO, write registers 7..12, unfreeze DCO, assert NewFreq.
- Sits between the button debouncer and the I2C register-write engine.

---
 rtl/si570_freq_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/si570_freq_sequencer.sv
// Button-driven Si570 frequency stepper: on each step pulse, selects the next preset
// and issues the freeze / RFREQ+dividers / unfreeze / NewFreq write sequence to the I2C writer.
module si570_freq_sequencer #(
    parameter logic [47:0] PRESET0       = 48'h01C2_BC01_1EB8,
    parameter logic [47:0] PRESET1       = 48'h21C2_BC01_1EB8,
    parameter logic [47:0] PRESET2       = 48'h4142_D1E1_2700,
    parameter logic [47:0] PRESET3       = 48'h6142_D1E1_2700,
    parameter bit          INIT_ON_RESET = 1'b1,
    parameter logic [6:0]  I2C_ADDR      = 7'h55
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       iStep,
    output logic       oWr_req,
    output logic [6:0] oWr_dev,
    output logic [7:0] oWr_addr,
    output logic [7:0] oWr_data,
    input  logic       iWr_ack,
    input  logic       iWr_err,
    output logic [1:0] oSel,
    output logic       oBusy,
    output logic       oDone,
    output logic       oErr
);

    typedef enum logic [1:0] {IDLE, ISSUE, ADVANCE, ABORT} state_t;

    state_t      state, state_nx;
    logic [3:0]  wi, wi_nx;
    logic [1:0]  sel, sel_nx;
    logic        pending, pending_nx;
    logic        init_pend, init_pend_nx;
    logic        aborting, aborting_nx;
    logic        err_q, err_nx;
    logic        done_q, done_nx;
    logic [47:0] preset_q, preset_nx;
    logic        start;

    function automatic logic [47:0] preset_of(input logic [1:0] idx);
        case (idx)
            2'd0:    preset_of = PRESET0;
            2'd1:    preset_of = PRESET1;
            2'd2:    preset_of = PRESET2;
            default: preset_of = PRESET3;
        endcase
    endfunction

    function automatic logic [7:0] addr_of(input logic [3:0] idx);
        case (idx)
            4'd0:    addr_of = 8'd137;
            4'd1:    addr_of = 8'd7;
            4'd2:    addr_of = 8'd8;
            4'd3:    addr_of = 8'd9;
            4'd4:    addr_of = 8'd10;
            4'd5:    addr_of = 8'd11;
            4'd6:    addr_of = 8'd12;
            4'd7:    addr_of = 8'd137;
            4'd8:    addr_of = 8'd135;
            default: addr_of = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] data_of(input logic [3:0] idx, input logic [47:0] p);
        case (idx)
            4'd0:    data_of = 8'h10;
            4'd1:    data_of = p[47:40];
            4'd2:    data_of = p[39:32];
            4'd3:    data_of = p[31:24];
            4'd4:    data_of = p[23:16];
            4'd5:    data_of = p[15:8];
            4'd6:    data_of = p[7:0];
            4'd7:    data_of = 8'h00;
            4'd8:    data_of = 8'h40;
            default: data_of = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_nx     = state;
        wi_nx        = wi;
        sel_nx       = sel;
        pending_nx   = pending;
        init_pend_nx = init_pend;
        aborting_nx  = aborting;
        err_nx       = err_q;
        done_nx      = 1'b0;
        preset_nx    = preset_q;
        start        = 1'b0;

        if (state != IDLE && iStep)
            pending_nx = 1'b1;

        case (state)
            IDLE: begin
                if (init_pend || pending || iStep)
                    start = 1'b1;
            end
            ISSUE: begin
                if (iWr_err) begin
                    err_nx = 1'b1;
                    // Mid-register failures must still unfreeze the DCO; route through the gap first
                    if (wi >= 4'd1 && wi <= 4'd6) begin
                        aborting_nx = 1'b1;
                        state_nx    = ADVANCE;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (iWr_ack) begin
                    if (wi == 4'd8) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        wi_nx    = wi + 4'd1;
                        state_nx = ADVANCE;
                    end
                end
            end
            ADVANCE: begin
                state_nx = aborting ? ABORT : ISSUE;
            end
            ABORT: begin
                if (iWr_ack || iWr_err) begin
                    aborting_nx = 1'b0;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (start) begin
            // The post-reset initial programming keeps preset 0 rather than stepping
            sel_nx       = init_pend ? sel : sel + 2'd1;
            pending_nx   = init_pend & iStep;
            init_pend_nx = 1'b0;
            wi_nx        = 4'd0;
            err_nx       = 1'b0;
            preset_nx    = preset_of(sel_nx);
            state_nx     = ISSUE;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state     <= IDLE;
            wi        <= 4'd0;
            sel       <= 2'd0;
            pending   <= 1'b0;
            init_pend <= INIT_ON_RESET;
            aborting  <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            wi        <= wi_nx;
            sel       <= sel_nx;
            pending   <= pending_nx;
            init_pend <= init_pend_nx;
            aborting  <= aborting_nx;
            err_q     <= err_nx;
            done_q    <= done_nx;
        end
    end

    always_ff @(posedge iCLK) begin
        preset_q <= preset_nx;
    end

    always_comb begin
        oWr_req  = 1'b0;
        oWr_addr = 8'd0;
        oWr_data = 8'd0;
        if (state == ISSUE) begin
            oWr_req  = 1'b1;
            oWr_addr = addr_of(wi);
            oWr_data = data_of(wi, preset_q);
        end else if (state == ABORT) begin
            oWr_req  = 1'b1;
            oWr_addr = 8'd137;
            oWr_data = 8'h00;
        end
    end

    assign oWr_dev = I2C_ADDR;
    assign oSel    = sel;
    assign oBusy   = (state != IDLE);
    assign oDone   = done_q;
    assign oErr    = err_q;

endmodule
